// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: ROB tag/data widths and the CDB broadcast record
// snooped by the ROB, reservation stations and commit.
package tomasulo_pkg;

    localparam int TAG_W     = 3;
    localparam int DATA_W    = 32;
    localparam int ROB_DEPTH = 1 << TAG_W;
    localparam int FU_COUNT  = 4;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    // Distance of an entry from the ROB head; smaller means older.
    function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU writeback requests, ROB control and the registered CDB broadcast.
// master = FU/ROB side, slave = arbiter.
interface cdb_arbiter_if #(parameter int NUM_FU = tomasulo_pkg::FU_COUNT);

    logic [NUM_FU-1:0]                     fu_req;
    logic [NUM_FU*tomasulo_pkg::TAG_W-1:0]  fu_tag;
    logic [NUM_FU*tomasulo_pkg::DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]                     fu_gnt;
    logic                                  cdb_stall;
    logic                                  rob_flush;
    logic [tomasulo_pkg::TAG_W-1:0]         rob_head;
    logic                                  cdb_valid;
    logic [tomasulo_pkg::TAG_W-1:0]         cdb_tag;
    logic [tomasulo_pkg::DATA_W-1:0]        cdb_data;

    modport master (
        output fu_req, fu_tag, fu_data, cdb_stall, rob_flush, rob_head,
        input  fu_gnt, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  fu_req, fu_tag, fu_data, cdb_stall, rob_flush, rob_head,
        output fu_gnt, cdb_valid, cdb_tag, cdb_data
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: first requester at or above ptr, wrapping.
module rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one FU result per cycle, broadcast registered.
// Build option CDB_OLDEST_FIRST_EN: grant the oldest ROB entry instead of round robin.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int NUM_FU = FU_COUNT
) (
    input logic         clk,
    input logic         rst,
    cdb_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grant_en;
    logic              grant;
    cdb_t              cdb_q;

    assign grant_en = !rst && !bus.cdb_stall && !bus.rob_flush;
    assign grant    = grant_en && pick_any;

`ifdef CDB_OLDEST_FIRST_EN
    logic [TAG_W-1:0] best_age;

    // Ties on age (only possible with duplicate tags) go to the lowest FU index.
    always_comb begin
        pick_idx = '0;
        pick_any = 1'b0;
        best_age = '1;
        pick_gnt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (bus.fu_req[i] &&
                (!pick_any || rob_age(bus.fu_tag[i*TAG_W +: TAG_W], bus.rob_head) < best_age)) begin
                pick_any = 1'b1;
                best_age = rob_age(bus.fu_tag[i*TAG_W +: TAG_W], bus.rob_head);
                pick_idx = IDX_W'(i);
            end
        end
        pick_gnt[pick_idx] = pick_any;
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    rr_pick #(.N(NUM_FU)) u_rr_pick (
        .req (bus.fu_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (pick_idx == IDX_W'(NUM_FU - 1)) ? '0 : pick_idx + 1'b1;
        end
    end
`endif

    assign bus.fu_gnt = grant_en ? pick_gnt : '0;

    // Tag/data hold their last value when nothing is broadcast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_q <= '0;
        end else if (bus.rob_flush) begin
            cdb_q.valid <= 1'b0;
        end else if (grant) begin
            cdb_q.valid <= 1'b1;
            cdb_q.tag   <= bus.fu_tag[pick_idx*TAG_W +: TAG_W];
            cdb_q.data  <= bus.fu_data[pick_idx*DATA_W +: DATA_W];
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_tag   = cdb_q.tag;
    assign bus.cdb_data  = cdb_q.data;

endmodule
